// File: rtl/riscv_wb_bus_arbiter.sv
// riscv_wb_bus_arbiter
//   Two-master Wishbone arbiter. Merges the instruction-fetch master (wb_ins_*)
//   and the data master (wb_dat_*) onto one shared master port (wb_*).
//   Round-robin between contending masters. The grant is locked for the whole
//   cyc period, so bursts are never split. A watchdog ends stalled transfers
//   with an error.
//
// Ports
//   HCLK, HRESETn          clock (rising edge), synchronous active-low reset
//   wb_ins_*_i / wb_ins_*_o instruction master request / response
//   wb_dat_*_i / wb_dat_*_o data master request / response
//   wb_*_o                 shared bus request (mux of the granted master)
//   wb_dat_i, wb_ack_i,
//   wb_err_i, wb_rty_i     shared bus response
//   timeout_o              one-cycle pulse when the watchdog fires
module riscv_wb_bus_arbiter #(
    parameter int XLEN    = 32,
    parameter int PLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            HCLK,
    input  logic            HRESETn,

    input  logic [PLEN-1:0] wb_ins_adr_i,
    input  logic [XLEN-1:0] wb_ins_dat_i,
    input  logic [3:0]      wb_ins_sel_i,
    input  logic            wb_ins_we_i,
    input  logic            wb_ins_cyc_i,
    input  logic            wb_ins_stb_i,
    input  logic [2:0]      wb_ins_cti_i,
    input  logic [1:0]      wb_ins_bte_i,
    output logic [XLEN-1:0] wb_ins_dat_o,
    output logic            wb_ins_ack_o,
    output logic            wb_ins_err_o,
    output logic [2:0]      wb_ins_rty_o,

    input  logic [PLEN-1:0] wb_dat_adr_i,
    input  logic [XLEN-1:0] wb_dat_dat_i,
    input  logic [3:0]      wb_dat_sel_i,
    input  logic            wb_dat_we_i,
    input  logic            wb_dat_cyc_i,
    input  logic            wb_dat_stb_i,
    input  logic [2:0]      wb_dat_cti_i,
    input  logic [1:0]      wb_dat_bte_i,
    output logic [XLEN-1:0] wb_dat_dat_o,
    output logic            wb_dat_ack_o,
    output logic            wb_dat_err_o,
    output logic [2:0]      wb_dat_rty_o,

    output logic [PLEN-1:0] wb_adr_o,
    output logic [XLEN-1:0] wb_dat_o,
    output logic [3:0]      wb_sel_o,
    output logic            wb_we_o,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic [2:0]      wb_cti_o,
    output logic [1:0]      wb_bte_o,
    input  logic [XLEN-1:0] wb_dat_i,
    input  logic            wb_ack_i,
    input  logic            wb_err_i,
    input  logic [2:0]      wb_rty_i,

    output logic            timeout_o
);

    typedef enum logic [1:0] {IDLE, GNT_INS, GNT_DAT} state_t;
    typedef enum logic       {LAST_INS, LAST_DAT}      last_t;

    // Counter must still be one bit wide when the watchdog is disabled.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    state_t          state_q, state_d;
    last_t           last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [PLEN-1:0] req_adr;
    logic [XLEN-1:0] req_dat;
    logic [3:0]      req_sel;
    logic            req_we, req_cyc, req_stb;
    logic [2:0]      req_cti;
    logic [1:0]      req_bte;
    logic            resp_any, stall, wd_fire;

    function automatic state_t arbitrate(input logic ins, input logic dat, input last_t last);
        if (ins && dat) return (last == LAST_DAT) ? GNT_INS : GNT_DAT;
        else if (ins)   return GNT_INS;
        else if (dat)   return GNT_DAT;
        else            return IDLE;
    endfunction

    // The owner keeps the grant for as long as its cyc is high (burst lock).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = arbitrate(wb_ins_cyc_i, wb_dat_cyc_i, last_q);
            GNT_INS: if (!wb_ins_cyc_i) state_d = arbitrate(wb_ins_cyc_i, wb_dat_cyc_i, last_q);
            GNT_DAT: if (!wb_dat_cyc_i) state_d = arbitrate(wb_ins_cyc_i, wb_dat_cyc_i, last_q);
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (state_d != state_q) begin
            if (state_d == GNT_INS)      last_d = LAST_INS;
            else if (state_d == GNT_DAT) last_d = LAST_DAT;
        end
    end

    always_comb begin
        req_adr = '0;
        req_dat = '0;
        req_sel = '0;
        req_we  = 1'b0;
        req_cyc = 1'b0;
        req_stb = 1'b0;
        req_cti = '0;
        req_bte = '0;
        case (state_q)
            GNT_INS: begin
                req_adr = wb_ins_adr_i;
                req_dat = wb_ins_dat_i;
                req_sel = wb_ins_sel_i;
                req_we  = wb_ins_we_i;
                req_cyc = wb_ins_cyc_i;
                req_stb = wb_ins_stb_i;
                req_cti = wb_ins_cti_i;
                req_bte = wb_ins_bte_i;
            end
            GNT_DAT: begin
                req_adr = wb_dat_adr_i;
                req_dat = wb_dat_dat_i;
                req_sel = wb_dat_sel_i;
                req_we  = wb_dat_we_i;
                req_cyc = wb_dat_cyc_i;
                req_stb = wb_dat_stb_i;
                req_cti = wb_dat_cti_i;
                req_bte = wb_dat_bte_i;
            end
            default: ;
        endcase
    end

    assign resp_any = wb_ack_i | wb_err_i | (|wb_rty_i);
    assign stall    = req_cyc & req_stb & ~resp_any;
    // Fires on the TIMEOUT-th stalled cycle; a same-cycle response clears
    // stall, so a slave ack always wins over the watchdog.
    assign wd_fire  = (TIMEOUT > 0) && stall && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE || state_d != state_q || resp_any || wd_fire)
            cnt_d = '0;
        else if (stall && TIMEOUT > 0)
            cnt_d = cnt_q + CW'(1);
    end

    assign wb_adr_o = req_adr;
    assign wb_dat_o = req_dat;
    assign wb_sel_o = req_sel;
    assign wb_we_o  = req_we;
    assign wb_cyc_o = req_cyc & ~wd_fire;
    assign wb_stb_o = req_stb & ~wd_fire;
    assign wb_cti_o = req_cti;
    assign wb_bte_o = req_bte;

    assign wb_ins_dat_o = wb_dat_i;
    assign wb_dat_dat_o = wb_dat_i;
    assign wb_ins_ack_o = (state_q == GNT_INS) & wb_ack_i;
    assign wb_dat_ack_o = (state_q == GNT_DAT) & wb_ack_i;
    assign wb_ins_err_o = (state_q == GNT_INS) & (wb_err_i | wd_fire);
    assign wb_dat_err_o = (state_q == GNT_DAT) & (wb_err_i | wd_fire);
    assign wb_ins_rty_o = (state_q == GNT_INS) ? wb_rty_i : '0;
    assign wb_dat_rty_o = (state_q == GNT_DAT) ? wb_rty_i : '0;
    assign timeout_o    = wd_fire;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q <= IDLE;
            last_q  <= LAST_DAT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_riscv_wb_bus_arbiter.sv
// tb_riscv_wb_bus_arbiter
//   Directed bench for riscv_wb_bus_arbiter. The main instance uses TIMEOUT=4;
//   a second instance with TIMEOUT=0 shares the same inputs for the
//   disabled-watchdog scenario.
module tb_riscv_wb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;

    logic [31:0] ins_adr, ins_wdat, dat_adr, dat_wdat, s_rdat;
    logic [3:0]  ins_sel, dat_sel;
    logic        ins_we, ins_cyc, ins_stb, dat_we, dat_cyc, dat_stb;
    logic [2:0]  ins_cti, dat_cti, s_rty;
    logic [1:0]  ins_bte, dat_bte;
    logic        s_ack, s_err;

    logic [31:0] ins_rdat, dm_rdat, m_adr, m_wdat;
    logic        ins_ack, ins_err, dm_ack, dm_err;
    logic [2:0]  ins_rty, dm_rty, m_cti;
    logic [3:0]  m_sel;
    logic        m_we, m_cyc, m_stb, tmo;
    logic [1:0]  m_bte;

    logic [31:0] z_ins_rdat, z_dm_rdat, z_adr, z_wdat;
    logic        z_ins_ack, z_ins_err, z_dm_ack, z_dm_err;
    logic [2:0]  z_ins_rty, z_dm_rty, z_cti;
    logic [3:0]  z_sel;
    logic        z_we, z_cyc, z_stb, z_tmo;
    logic [1:0]  z_bte;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    riscv_wb_bus_arbiter #(.XLEN(32), .PLEN(32), .TIMEOUT(4)) dut (
        .HCLK(clk), .HRESETn(rstn),
        .wb_ins_adr_i(ins_adr), .wb_ins_dat_i(ins_wdat), .wb_ins_sel_i(ins_sel),
        .wb_ins_we_i(ins_we), .wb_ins_cyc_i(ins_cyc), .wb_ins_stb_i(ins_stb),
        .wb_ins_cti_i(ins_cti), .wb_ins_bte_i(ins_bte),
        .wb_ins_dat_o(ins_rdat), .wb_ins_ack_o(ins_ack), .wb_ins_err_o(ins_err),
        .wb_ins_rty_o(ins_rty),
        .wb_dat_adr_i(dat_adr), .wb_dat_dat_i(dat_wdat), .wb_dat_sel_i(dat_sel),
        .wb_dat_we_i(dat_we), .wb_dat_cyc_i(dat_cyc), .wb_dat_stb_i(dat_stb),
        .wb_dat_cti_i(dat_cti), .wb_dat_bte_i(dat_bte),
        .wb_dat_dat_o(dm_rdat), .wb_dat_ack_o(dm_ack), .wb_dat_err_o(dm_err),
        .wb_dat_rty_o(dm_rty),
        .wb_adr_o(m_adr), .wb_dat_o(m_wdat), .wb_sel_o(m_sel), .wb_we_o(m_we),
        .wb_cyc_o(m_cyc), .wb_stb_o(m_stb), .wb_cti_o(m_cti), .wb_bte_o(m_bte),
        .wb_dat_i(s_rdat), .wb_ack_i(s_ack), .wb_err_i(s_err), .wb_rty_i(s_rty),
        .timeout_o(tmo)
    );

    riscv_wb_bus_arbiter #(.XLEN(32), .PLEN(32), .TIMEOUT(0)) dut0 (
        .HCLK(clk), .HRESETn(rstn),
        .wb_ins_adr_i(ins_adr), .wb_ins_dat_i(ins_wdat), .wb_ins_sel_i(ins_sel),
        .wb_ins_we_i(ins_we), .wb_ins_cyc_i(ins_cyc), .wb_ins_stb_i(ins_stb),
        .wb_ins_cti_i(ins_cti), .wb_ins_bte_i(ins_bte),
        .wb_ins_dat_o(z_ins_rdat), .wb_ins_ack_o(z_ins_ack), .wb_ins_err_o(z_ins_err),
        .wb_ins_rty_o(z_ins_rty),
        .wb_dat_adr_i(dat_adr), .wb_dat_dat_i(dat_wdat), .wb_dat_sel_i(dat_sel),
        .wb_dat_we_i(dat_we), .wb_dat_cyc_i(dat_cyc), .wb_dat_stb_i(dat_stb),
        .wb_dat_cti_i(dat_cti), .wb_dat_bte_i(dat_bte),
        .wb_dat_dat_o(z_dm_rdat), .wb_dat_ack_o(z_dm_ack), .wb_dat_err_o(z_dm_err),
        .wb_dat_rty_o(z_dm_rty),
        .wb_adr_o(z_adr), .wb_dat_o(z_wdat), .wb_sel_o(z_sel), .wb_we_o(z_we),
        .wb_cyc_o(z_cyc), .wb_stb_o(z_stb), .wb_cti_o(z_cti), .wb_bte_o(z_bte),
        .wb_dat_i(s_rdat), .wb_ack_i(s_ack), .wb_err_i(s_err), .wb_rty_i(s_rty),
        .timeout_o(z_tmo)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        ins_adr = '0; ins_wdat = '0; ins_sel = '0; ins_we = 1'b0;
        ins_cyc = 1'b0; ins_stb = 1'b0; ins_cti = '0; ins_bte = '0;
        dat_adr = '0; dat_wdat = '0; dat_sel = '0; dat_we = 1'b0;
        dat_cyc = 1'b0; dat_stb = 1'b0; dat_cti = '0; dat_bte = '0;
        s_rdat = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset;
        idle_inputs();
        rstn = 1'b0;
        ins_cyc = 1'b1; ins_stb = 1'b1; ins_adr = 32'h0000_0040;
        s_ack = 1'b1;
        tick();
        checks++; if (m_cyc !== 1'b0) begin errors++; $display("FAIL reset_cyc: got %b expected 0", m_cyc); end
        checks++; if (m_stb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b expected 0", m_stb); end
        checks++; if (m_adr !== 32'h0) begin errors++; $display("FAIL reset_adr: got %h expected 0", m_adr); end
        checks++; if (ins_ack !== 1'b0) begin errors++; $display("FAIL reset_ins_ack: got %b expected 0", ins_ack); end
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", tmo); end
        idle_inputs();
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_ins_single;
        ins_cyc = 1'b1; ins_stb = 1'b1; ins_adr = 32'h8000_0000; ins_sel = 4'hF;
        #1;
        checks++; if (m_cyc !== 1'b0) begin errors++; $display("FAIL single_latency: got cyc %b expected 0", m_cyc); end
        tick();
        checks++; if (m_cyc !== 1'b1) begin errors++; $display("FAIL single_cyc: got %b expected 1", m_cyc); end
        checks++; if (m_adr !== 32'h8000_0000) begin errors++; $display("FAIL single_adr: got %h expected 80000000", m_adr); end
        s_ack = 1'b1; s_rdat = 32'h1234_5678;
        #1;
        checks++; if (ins_ack !== 1'b1) begin errors++; $display("FAIL single_ins_ack: got %b expected 1", ins_ack); end
        checks++; if (ins_rdat !== 32'h1234_5678) begin errors++; $display("FAIL single_ins_dat: got %h expected 12345678", ins_rdat); end
        checks++; if (dm_ack !== 1'b0) begin errors++; $display("FAIL single_dat_ack: got %b expected 0", dm_ack); end
        tick();
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_contend;
        do_reset();
        ins_cyc = 1'b1; ins_stb = 1'b1; ins_adr = 32'h0000_1000;
        dat_cyc = 1'b1; dat_stb = 1'b1; dat_adr = 32'h0000_2000;
        tick();
        checks++; if (m_adr !== 32'h0000_1000) begin errors++; $display("FAIL contend_first: got %h expected 00001000", m_adr); end
        s_ack = 1'b1;
        #1;
        checks++; if (ins_ack !== 1'b1 || dm_ack !== 1'b0) begin errors++; $display("FAIL contend_route: got ins %b dat %b expected 1 0", ins_ack, dm_ack); end
        tick();
        ins_cyc = 1'b0; ins_stb = 1'b0; s_ack = 1'b0;
        tick();
        checks++; if (m_cyc !== 1'b1) begin errors++; $display("FAIL contend_no_bubble: got cyc %b expected 1", m_cyc); end
        checks++; if (m_adr !== 32'h0000_2000) begin errors++; $display("FAIL contend_second: got %h expected 00002000", m_adr); end
        s_ack = 1'b1;
        #1;
        checks++; if (dm_ack !== 1'b1 || ins_ack !== 1'b0) begin errors++; $display("FAIL contend_route2: got ins %b dat %b expected 0 1", ins_ack, dm_ack); end
        tick();
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_burst;
        logic [31:0] exp_adr;
        logic [2:0]  exp_cti;
        ins_cyc = 1'b1; ins_stb = 1'b1; ins_adr = 32'h0000_3000; ins_cti = 3'b010;
        dat_adr = 32'h0000_4000;
        tick();
        for (int b = 0; b < 8; b++) begin
            exp_adr = 32'h0000_3000 + 32'(4 * b);
            exp_cti = (b == 7) ? 3'b111 : 3'b010;
            ins_adr = exp_adr; ins_cti = exp_cti;
            if (b >= 1) begin dat_cyc = 1'b1; dat_stb = 1'b1; end
            s_ack = 1'b1;
            #1;
            checks++; if (m_adr !== exp_adr) begin errors++; $display("FAIL burst_adr beat %0d: got %h expected %h", b, m_adr, exp_adr); end
            checks++; if (m_cti !== exp_cti) begin errors++; $display("FAIL burst_cti beat %0d: got %b expected %b", b, m_cti, exp_cti); end
            checks++; if (ins_ack !== 1'b1 || dm_ack !== 1'b0) begin errors++; $display("FAIL burst_route beat %0d: got ins %b dat %b expected 1 0", b, ins_ack, dm_ack); end
            tick();
        end
        ins_cyc = 1'b0; ins_stb = 1'b0; ins_cti = '0; s_ack = 1'b0;
        tick();
        checks++; if (m_adr !== 32'h0000_4000 || m_cyc !== 1'b1) begin errors++; $display("FAIL burst_then_dat: got adr %h cyc %b expected 00004000 1", m_adr, m_cyc); end
        s_ack = 1'b1;
        tick();
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_round_robin;
        logic exp_ins;
        ins_cyc = 1'b1; ins_stb = 1'b1; ins_adr = 32'h0000_0100;
        dat_cyc = 1'b1; dat_stb = 1'b1; dat_adr = 32'h0000_0200;
        tick();
        for (int i = 0; i < 6; i++) begin
            exp_ins = (i % 2 == 0);
            checks++; if (m_adr !== (exp_ins ? 32'h0000_0100 : 32'h0000_0200)) begin errors++; $display("FAIL rr_grant txn %0d: got adr %h expected ins=%b", i, m_adr, exp_ins); end
            s_ack = 1'b1;
            #1;
            checks++; if (ins_ack !== exp_ins || dm_ack !== !exp_ins) begin errors++; $display("FAIL rr_route txn %0d: got ins %b dat %b expected ins=%b", i, ins_ack, dm_ack, exp_ins); end
            tick();
            s_ack = 1'b0;
            if (exp_ins) begin ins_cyc = 1'b0; ins_stb = 1'b0; end
            else begin dat_cyc = 1'b0; dat_stb = 1'b0; end
            tick();
            ins_cyc = 1'b1; ins_stb = 1'b1; dat_cyc = 1'b1; dat_stb = 1'b1;
        end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_watchdog;
        dat_cyc = 1'b1; dat_stb = 1'b1; dat_adr = 32'h0000_0300;
        tick();
        for (int k = 1; k <= 3; k++) begin
            checks++; if (dm_err !== 1'b0 || tmo !== 1'b0 || m_stb !== 1'b1) begin errors++; $display("FAIL wd_early cycle %0d: got err %b tmo %b stb %b expected 0 0 1", k, dm_err, tmo, m_stb); end
            tick();
        end
        checks++; if (dm_err !== 1'b1) begin errors++; $display("FAIL wd_err: got %b expected 1", dm_err); end
        checks++; if (tmo !== 1'b1) begin errors++; $display("FAIL wd_timeout: got %b expected 1", tmo); end
        checks++; if (m_stb !== 1'b0 || m_cyc !== 1'b0) begin errors++; $display("FAIL wd_bus_forced: got stb %b cyc %b expected 0 0", m_stb, m_cyc); end
        checks++; if (ins_err !== 1'b0) begin errors++; $display("FAIL wd_ins_err: got %b expected 0", ins_err); end
        tick();
        dat_cyc = 1'b0; dat_stb = 1'b0;
        #1;
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL wd_pulse_len: got %b expected 0", tmo); end
        tick();
        tick();
        // Slave ack on the would-be timeout cycle
        dat_cyc = 1'b1; dat_stb = 1'b1;
        tick();
        tick();
        tick();
        tick();
        s_ack = 1'b1;
        #1;
        checks++; if (dm_ack !== 1'b1 || dm_err !== 1'b0 || tmo !== 1'b0 || m_stb !== 1'b1) begin errors++; $display("FAIL wd_ack_priority: got ack %b err %b tmo %b stb %b expected 1 0 0 1", dm_ack, dm_err, tmo, m_stb); end
        tick();
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_timeout_disabled;
        logic seen = 1'b0;
        dat_cyc = 1'b1; dat_stb = 1'b1; dat_adr = 32'h0000_0600;
        tick();
        for (int c = 0; c < 1000; c++) begin
            if (z_dm_err !== 1'b0 || z_tmo !== 1'b0) seen = 1'b1;
            tick();
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL wd_disabled: got err/timeout %b expected 0", seen); end
        checks++; if (z_stb !== 1'b1) begin errors++; $display("FAIL wd_disabled_stb: got %b expected 1", z_stb); end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_reset_mid;
        dat_cyc = 1'b1; dat_stb = 1'b1; dat_adr = 32'h0000_0400; dat_cti = 3'b010;
        tick();
        s_ack = 1'b1;
        tick();
        dat_adr = 32'h0000_0404;
        #1;
        checks++; if (dm_ack !== 1'b1 || m_adr !== 32'h0000_0404) begin errors++; $display("FAIL rstmid_beat: got ack %b adr %h expected 1 00000404", dm_ack, m_adr); end
        s_ack = 1'b0;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        checks++; if (m_cyc !== 1'b0 || m_stb !== 1'b0) begin errors++; $display("FAIL rstmid_bus: got cyc %b stb %b expected 0 0", m_cyc, m_stb); end
        checks++; if (m_adr !== 32'h0 || m_cti !== 3'b000 || tmo !== 1'b0) begin errors++; $display("FAIL rstmid_outputs: got adr %h cti %b tmo %b expected 0", m_adr, m_cti, tmo); end
        s_ack = 1'b1;
        #1;
        checks++; if (dm_ack !== 1'b0 || ins_ack !== 1'b0) begin errors++; $display("FAIL rstmid_no_completion: got ins %b dat %b expected 0 0", ins_ack, dm_ack); end
        s_ack = 1'b0;
        ins_cyc = 1'b1; ins_stb = 1'b1; ins_adr = 32'h0000_0500;
        tick();
        checks++; if (m_adr !== 32'h0000_0500 || m_cyc !== 1'b1) begin errors++; $display("FAIL rstmid_ins_wins: got adr %h cyc %b expected 00000500 1", m_adr, m_cyc); end
        s_ack = 1'b1;
        tick();
        idle_inputs();
        tick();
        tick();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_ins_single();
        test_contend();
        test_burst();
        test_round_robin();
        test_watchdog();
        test_timeout_disabled();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
